// File: rtl/instr_issue_unit.sv
// Program FIFO and issue sequencer for the 3-stage ALU pipeline.
// Inserts bubbles on RAW hazards and tags write-back results with rd.
module instr_issue_unit #(
  parameter int DEPTH      = 16,
  parameter int HAZARD_GAP = 3,
  parameter int RES_LAT    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  input  logic [31:0] load_instr,
  output logic        load_ready,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] pipe_instr,
  output logic        pipe_we,
  input  logic [31:0] pipe_out,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic [4:0]  res_rd,
  output logic [15:0] issue_count,
  output logic [15:0] stall_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int HW = HAZARD_GAP - 1;
  localparam int DW = $clog2(RES_LAT + 1);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(RES_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [31:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;

  logic [HW-1:0] haz_we_q, haz_we_d;
  logic [HW-1:0][4:0] haz_rd_q, haz_rd_d;
  logic [RES_LAT-1:0] res_we_q, res_we_d;
  logic [RES_LAT-1:0][4:0] res_rd_q, res_rd_d;
  logic [31:0] res_data_q, res_data_d;

  logic [15:0] issue_cnt_q, issue_cnt_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [DW-1:0] drain_q, drain_d;

  logic [31:0] head;
  logic [4:0] rs1, rs2;
  logic full, empty, accept, clr;
  logic issue, stall, head_hazard, idle_or_done;

  assign head = mem_q[rd_ptr_q];
  assign rs1 = head[25:21];
  assign rs2 = head[15:11];
  assign full = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept = load_valid && load_ready;
  assign clr = start && idle_or_done;
  assign issue = pipe_we;
  assign stall = (state_q == S_RUN) && head_hazard;

  // A reader may issue HAZARD_GAP cycles after its writer, so only
  // the previous HAZARD_GAP-1 issue slots can conflict.
  always_comb begin
    head_hazard = 1'b0;
    for (int i = 0; i < HW; i++) begin
      if (haz_we_q[i] &&
          (haz_rd_q[i] == rs1 ||
           (!head[28] && haz_rd_q[i] == rs2)))
        head_hazard = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start)
          state_d = (!empty || accept) ? S_RUN : S_DONE;
        else if (accept)
          state_d = S_IDLE;
      end
      S_RUN: begin
        if (issue && count_q == CNT_ONE)
          state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST)
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    pipe_we    = 1'b0;
    pipe_instr = '0;
    unique case (state_q)
      S_IDLE: load_ready = !full;
      S_DONE: begin
        load_ready = !full;
        done       = 1'b1;
      end
      S_RUN: begin
        busy = 1'b1;
        if (!head_hazard) begin
          pipe_we    = 1'b1;
          pipe_instr = head;
        end
      end
      S_DRAIN: busy = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end else if (issue) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q] <= load_instr;
  end

  // pipe_out carries an issue's value in the slot just before
  // res_valid, so res_we_q[RES_LAT-2] gates the data capture.
  always_comb begin
    haz_we_d[0] = issue;
    haz_rd_d[0] = issue ? head[20:16] : 5'd0;
    for (int i = 1; i < HW; i++) begin
      haz_we_d[i] = haz_we_q[i-1];
      haz_rd_d[i] = haz_rd_q[i-1];
    end
    res_we_d[0] = issue;
    res_rd_d[0] = issue ? head[20:16] : 5'd0;
    for (int i = 1; i < RES_LAT; i++) begin
      res_we_d[i] = res_we_q[i-1];
      res_rd_d[i] = res_rd_q[i-1];
    end
    res_data_d = res_we_q[RES_LAT-2] ? pipe_out : res_data_q;
  end

  always_comb begin
    issue_cnt_d = issue_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (clr) begin
      issue_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (issue && issue_cnt_q != 16'hFFFF)
        issue_cnt_d = issue_cnt_q + 16'd1;
      if (stall && stall_cnt_q != 16'hFFFF)
        stall_cnt_d = stall_cnt_q + 16'd1;
    end
    drain_d = (state_q == S_DRAIN) ? drain_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      haz_we_q    <= '0;
      haz_rd_q    <= '0;
      res_we_q    <= '0;
      res_rd_q    <= '0;
      res_data_q  <= '0;
      issue_cnt_q <= '0;
      stall_cnt_q <= '0;
      drain_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      haz_we_q    <= haz_we_d;
      haz_rd_q    <= haz_rd_d;
      res_we_q    <= res_we_d;
      res_rd_q    <= res_rd_d;
      res_data_q  <= res_data_d;
      issue_cnt_q <= issue_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      drain_q     <= drain_d;
    end
  end

  assign res_valid   = res_we_q[RES_LAT-1];
  assign res_rd      = res_rd_q[RES_LAT-1];
  assign res_data    = res_data_q;
  assign issue_count = issue_cnt_q;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_instr_issue_unit.sv
// Bench for instr_issue_unit with a behavioural 3-stage ALU pipeline.
// Table-driven program runs plus FIFO, reset and empty-start sequences.
module tb_instr_issue_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_instr = '0;
  logic        start = 1'b0;
  logic        load_ready, busy, done, pipe_we, res_valid;
  logic [31:0] pipe_instr, pipe_out, res_data;
  logic [4:0]  res_rd;
  logic [15:0] issue_count, stall_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  instr_issue_unit dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_instr(load_instr),
    .load_ready(load_ready), .start(start),
    .busy(busy), .done(done),
    .pipe_instr(pipe_instr), .pipe_we(pipe_we),
    .pipe_out(pipe_out), .res_valid(res_valid),
    .res_data(res_data), .res_rd(res_rd),
    .issue_count(issue_count), .stall_count(stall_count)
  );

  // Pipeline stand-in: operands read at the issue edge, value on Out
  // two cycles later, register written back the edge after that.
  logic [31:0] regs [32] = '{default: 32'h0};
  logic        s1_we = 1'b0, s2_we = 1'b0;
  logic [4:0]  s1_rd = '0, s2_rd = '0;
  logic [31:0] s1_v = '0, s2_v = '0;

  always @(posedge clk) begin
    s1_we <= pipe_we;
    s1_rd <= pipe_instr[20:16];
    s1_v  <= pipe_instr[28] ?
             regs[pipe_instr[25:21]] + {16'h0, pipe_instr[15:0]} :
             regs[pipe_instr[25:21]] + regs[pipe_instr[15:11]];
    s2_we <= s1_we;
    s2_rd <= s1_rd;
    s2_v  <= s1_v;
    if (s2_we) regs[s2_rd] <= s2_v;
  end
  assign pipe_out = s2_v;

  int cyc = 0, we_seen = 0, rv_seen = 0;
  logic [31:0] iss_q [$];
  int          iss_cyc [$];
  logic [4:0]  rrd_q [$];
  logic [31:0] rdat_q [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (pipe_we === 1'b1) begin
      iss_q.push_back(pipe_instr);
      iss_cyc.push_back(cyc);
      we_seen <= we_seen + 1;
    end
    if (res_valid === 1'b1) begin
      rrd_q.push_back(res_rd);
      rdat_q.push_back(res_data);
      rv_seen <= rv_seen + 1;
    end
  end

  function automatic logic [31:0] mk(bit src, logic [4:0] rs1,
                                     logic [4:0] rd, logic [15:0] imm);
    return {3'b000, src, 2'b00, rs1, rd, imm};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic load_word(input logic [31:0] w, output bit acc);
    load_valid = 1'b1;
    load_instr = w;
    acc = load_ready;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  task automatic wait_done(string nm);
    for (int k = 0; k < 300 && !done; k++) @(negedge clk);
    chk({nm, " done"}, {31'b0, done}, 32'd1);
    @(negedge clk);
  endtask

  task automatic run_prog(string nm, output int bi, output int br);
    bi = iss_q.size();
    br = rrd_q.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nm);
  endtask

  typedef struct {
    string       name;
    int          n;
    logic [31:0] w [3];
    int          stalls;
    int          gap;
    logic [4:0]  rd [3];
    logic [31:0] res [3];
  } vec_t;

  vec_t vecs [4];
  logic [31:0] wa [16];
  logic [31:0] wb [16];

  initial begin
    int bi, br, errs, nacc, base_we, base_rv;
    bit acc;

    vecs[0].name = "t1 indep";  vecs[0].n = 3;
    vecs[0].w[0] = mk(1, 4, 1, 16'h0011);
    vecs[0].w[1] = mk(1, 5, 2, 16'h0022);
    vecs[0].w[2] = mk(1, 6, 3, 16'h0033);
    vecs[0].stalls = 0; vecs[0].gap = 1;
    vecs[0].rd[0] = 1; vecs[0].rd[1] = 2; vecs[0].rd[2] = 3;
    vecs[0].res[0] = 32'h11; vecs[0].res[1] = 32'h22;
    vecs[0].res[2] = 32'h33;

    vecs[1].name = "t2 raw rs1"; vecs[1].n = 2;
    vecs[1].w[0] = mk(1, 1, 5, 16'h0100);
    vecs[1].w[1] = mk(1, 5, 6, 16'h0001);
    vecs[1].w[2] = '0;
    vecs[1].stalls = 2; vecs[1].gap = 3;
    vecs[1].rd[0] = 5; vecs[1].rd[1] = 6; vecs[1].rd[2] = 0;
    vecs[1].res[0] = 32'h111; vecs[1].res[1] = 32'h112;
    vecs[1].res[2] = '0;

    vecs[2].name = "t3 rs2 imm"; vecs[2].n = 2;
    vecs[2].w[0] = mk(1, 2, 7, 16'h0005);
    vecs[2].w[1] = mk(1, 3, 8, 16'h3800);
    vecs[2].w[2] = '0;
    vecs[2].stalls = 0; vecs[2].gap = 1;
    vecs[2].rd[0] = 7; vecs[2].rd[1] = 8; vecs[2].rd[2] = 0;
    vecs[2].res[0] = 32'h27; vecs[2].res[1] = 32'h3833;
    vecs[2].res[2] = '0;

    vecs[3].name = "t3 rs2 reg"; vecs[3].n = 2;
    vecs[3].w[0] = mk(1, 2, 7, 16'h0006);
    vecs[3].w[1] = mk(0, 3, 9, 16'h3800);
    vecs[3].w[2] = '0;
    vecs[3].stalls = 2; vecs[3].gap = 3;
    vecs[3].rd[0] = 7; vecs[3].rd[1] = 9; vecs[3].rd[2] = 0;
    vecs[3].res[0] = 32'h28; vecs[3].res[1] = 32'h5B;
    vecs[3].res[2] = '0;

    for (int i = 0; i < 16; i++) begin
      wa[i] = mk(1, 31, 5'(i), 16'hA000 + 16'(i));
      wb[i] = mk(1, 31, 5'(i), 16'hB000 + 16'(i));
    end

    repeat (3) @(negedge clk);
    chk("rst load_ready", {31'b0, load_ready}, 32'd1);
    chk("rst done", {31'b0, done}, 32'd0);
    chk("rst busy", {31'b0, busy}, 32'd0);
    chk("rst pipe_we", {31'b0, pipe_we}, 32'd0);
    chk("rst pipe_instr", pipe_instr, 32'd0);
    chk("rst res_valid", {31'b0, res_valid}, 32'd0);
    chk("rst res_data", res_data, 32'd0);
    chk("rst counts", {issue_count, stall_count}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].n; i++) begin
        load_word(vecs[v].w[i], acc);
        chk({vecs[v].name, " load"}, {31'b0, acc}, 32'd1);
      end
      run_prog(vecs[v].name, bi, br);
      chk({vecs[v].name, " issue_count"}, {16'h0, issue_count},
          vecs[v].n);
      chk({vecs[v].name, " stall_count"}, {16'h0, stall_count},
          vecs[v].stalls);
      chk({vecs[v].name, " n_issued"}, iss_q.size() - bi, vecs[v].n);
      chk({vecs[v].name, " n_results"}, rrd_q.size() - br, vecs[v].n);
      for (int i = 0; i < vecs[v].n; i++) begin
        if (bi + i < iss_q.size())
          chk({vecs[v].name, " issue order"}, iss_q[bi+i],
              vecs[v].w[i]);
        if (i > 0 && bi + i < iss_cyc.size())
          chk({vecs[v].name, " issue gap"},
              iss_cyc[bi+i] - iss_cyc[bi+i-1], vecs[v].gap);
        if (br + i < rrd_q.size()) begin
          chk({vecs[v].name, " res_rd"}, {27'b0, rrd_q[br+i]},
              {27'b0, vecs[v].rd[i]});
          chk({vecs[v].name, " res_data"}, rdat_q[br+i],
              vecs[v].res[i]);
        end
      end
    end

    nacc = 0;
    for (int i = 0; i < 16; i++) begin
      load_word(wa[i], acc);
      nacc += int'(acc);
      if (i == 0) chk("t4 done cleared by load", {31'b0, done}, 32'd0);
    end
    chk("t4 accepted A", nacc, 16);
    load_valid = 1'b1;
    load_instr = 32'hFFFF_0000;
    chk("t4 full load_ready", {31'b0, load_ready}, 32'd0);
    @(negedge clk);
    load_valid = 1'b0;
    run_prog("t4 A", bi, br);
    chk("t4 A issue_count", {16'h0, issue_count}, 32'd16);
    chk("t4 A results", rrd_q.size() - br, 16);
    errs = 0;
    for (int i = 0; i < 16; i++)
      if (bi + i >= iss_q.size() || iss_q[bi+i] !== wa[i]) errs++;
    chk("t4 A order errors", errs, 0);

    nacc = 0;
    for (int i = 0; i < 16; i++) begin
      load_word(wb[i], acc);
      nacc += int'(acc);
    end
    chk("t4 accepted B", nacc, 16);
    run_prog("t4 B", bi, br);
    chk("t4 B issue_count", {16'h0, issue_count}, 32'd16);
    errs = 0;
    for (int i = 0; i < 16; i++)
      if (bi + i >= iss_q.size() || iss_q[bi+i] !== wb[i]) errs++;
    chk("t4 B order errors", errs, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done empty start done", {31'b0, done}, 32'd1);
    chk("done empty start clr", {16'h0, issue_count}, 32'd0);

    for (int i = 0; i < 5; i++) begin
      load_word(mk(1, 31, 5'(16 + i), 16'(i + 1)), acc);
      chk("t5 load", {31'b0, acc}, 32'd1);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && issue_count != 16'd2; k++)
      @(negedge clk);
    chk("t5 reached 2 issued", {16'h0, issue_count}, 32'd2);
    rst = 1'b0;
    #1;
    chk("t5 rst load_ready", {31'b0, load_ready}, 32'd1);
    chk("t5 rst busy/done", {30'b0, busy, done}, 32'd0);
    chk("t5 rst pipe", {pipe_instr[30:0], pipe_we}, 32'd0);
    chk("t5 rst res", {res_data[25:0], res_rd, res_valid}, 32'd0);
    chk("t5 rst counts", {issue_count, stall_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    base_we = we_seen;
    base_rv = rv_seen;
    repeat (6) @(negedge clk);
    chk("t5 res_valid after release", rv_seen - base_rv, 0);

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t6 done next cycle", {31'b0, done}, 32'd1);
    chk("t6 issue_count", {16'h0, issue_count}, 32'd0);
    repeat (6) @(negedge clk);
    chk("t5/t6 pipe_we never", we_seen - base_we, 0);
    chk("t6 done held", {31'b0, done}, 32'd1);

    load_word(32'h1000_0077 | mk(1, 31, 20, 16'h0), acc);
    chk("t7 load0", {31'b0, acc}, 32'd1);
    bi = iss_q.size();
    load_valid = 1'b1;
    load_instr = mk(1, 31, 21, 16'h0088);
    start = 1'b1;
    @(negedge clk);
    load_valid = 1'b0;
    start = 1'b0;
    wait_done("t7");
    chk("t7 issue_count", {16'h0, issue_count}, 32'd2);
    chk("t7 n_issued", iss_q.size() - bi, 2);
    if (bi + 1 < iss_q.size())
      chk("t7 second word", iss_q[bi+1], mk(1, 31, 21, 16'h0088));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
